// File: rtl/conv_window_mac.sv
// K*K window dot-product engine: tracks raster position to qualify windows and
// computes the signed multiply-accumulate in a 3-stage, ce-gated pipeline.
module conv_window_mac #(
  parameter  int WIDTH = 8,
  parameter  int N     = 5,
  parameter  int K     = 3,
  parameter  int S     = 1,
  localparam int ACC_W = 2*WIDTH + $clog2(K*K)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [K*K*WIDTH-1:0]   window,
  input  logic [K*K*WIDTH-1:0]   weights,
  output logic [ACC_W-1:0]       conv_out,
  output logic                   conv_valid,
  output logic                   frame_done
);

  localparam int TAPS = K*K;
  localparam int PW   = 2*WIDTH;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N-1);

  logic [CW-1:0] col, row;
  logic          win_ok, last_pix;
  int            col_off, row_off;

  logic signed [PW-1:0]    prod [TAPS];
  logic signed [ACC_W-1:0] sum_comb, sum2;
  logic                    v1, l1, v2, l2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (ce) begin
      if (col == LAST) begin
        col <= '0;
        row <= (row == LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // A window is usable only once K-1 full columns and rows have been seen,
  // which also rejects windows that would straddle a row wrap.
  always_comb begin
    col_off  = int'(col) - (K-1);
    row_off  = int'(row) - (K-1);
    win_ok   = (col_off >= 0) && (row_off >= 0) &&
               ((col_off % S) == 0) && ((row_off % S) == 0);
    last_pix = (col == LAST) && (row == LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) prod[i] <= '0;
      v1 <= 1'b0;
      l1 <= 1'b0;
    end else if (ce) begin
      for (int i = 0; i < TAPS; i++)
        prod[i] <= PW'($signed(window[i*WIDTH +: WIDTH])) *
                   PW'($signed(weights[i*WIDTH +: WIDTH]));
      v1 <= win_ok;
      l1 <= last_pix;
    end
  end

  always_comb begin
    sum_comb = '0;
    for (int i = 0; i < TAPS; i++) sum_comb = sum_comb + ACC_W'(prod[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum2 <= '0;
      v2   <= 1'b0;
      l2   <= 1'b0;
    end else if (ce) begin
      sum2 <= sum_comb;
      v2   <= v1;
      l2   <= l1;
    end
  end

  // Flags drop after any stalled edge so a frozen pipe never re-reports a result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conv_out   <= '0;
      conv_valid <= 1'b0;
      frame_done <= 1'b0;
    end else if (ce) begin
      conv_out   <= sum2;
      conv_valid <= v2;
      frame_done <= l2;
    end else begin
      conv_valid <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_mac.sv
// Randomized bench for conv_window_mac: a queue-based reference model predicts
// each window result from raster position and plain dot-product arithmetic.
module tb_conv_window_mac;

  localparam int WIDTH = 8;
  localparam int N     = 5;
  localparam int K     = 3;
  localparam int TAPS  = K*K;
  localparam int ACC_W = 2*WIDTH + $clog2(TAPS);

  typedef logic [TAPS*WIDTH-1:0] vec_t;
  typedef struct {bit v; bit l; int val;} ent_t;

  logic clk = 1'b0;
  logic rst, ce;
  vec_t window, weights;
  logic [ACC_W-1:0] out1, out2;
  logic valid1, valid2, done1, done2;

  int total = 0;
  int bad   = 0;

  ent_t q1[$], q2[$];
  int   pix;
  bit   ev1, ed1, ev2, ed2;
  int   eo1, eo2;

  conv_window_mac #(.WIDTH(WIDTH), .N(N), .K(K), .S(1)) dut (
    .clk(clk), .rst(rst), .ce(ce), .window(window), .weights(weights),
    .conv_out(out1), .conv_valid(valid1), .frame_done(done1));

  conv_window_mac #(.WIDTH(WIDTH), .N(N), .K(K), .S(2)) dut_s2 (
    .clk(clk), .rst(rst), .ce(ce), .window(window), .weights(weights),
    .conv_out(out2), .conv_valid(valid2), .frame_done(done2));

  always #5 clk = ~clk;

  function automatic int dot(input vec_t w, input vec_t k);
    int acc = 0;
    for (int i = 0; i < TAPS; i++)
      acc += int'($signed(w[i*WIDTH +: WIDTH])) * int'($signed(k[i*WIDTH +: WIDTH]));
    return acc;
  endfunction

  function automatic bit on_grid(input int p, input int s);
    int r = p / N;
    int c = p % N;
    return (r >= K-1) && (c >= K-1) && ((r-(K-1)) % s == 0) && ((c-(K-1)) % s == 0);
  endfunction

  function automatic vec_t rep(input int x);
    vec_t v;
    for (int i = 0; i < TAPS; i++) v[i*WIDTH +: WIDTH] = WIDTH'(x);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < TAPS; i++) v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    return v;
  endfunction

  // Two bubbles ahead of the first real entry give a 3-edge result latency.
  task automatic model_reset();
    ent_t z = '{v: 1'b0, l: 1'b0, val: 0};
    q1.delete();
    q2.delete();
    for (int i = 0; i < 2; i++) begin
      q1.push_back(z);
      q2.push_back(z);
    end
    pix = 0;
    ev1 = 0; ed1 = 0; eo1 = 0;
    ev2 = 0; ed2 = 0; eo2 = 0;
  endtask

  task automatic model_edge(input bit c);
    ent_t e, f;
    if (c) begin
      e.val = dot(window, weights);
      e.l   = (pix == N*N-1);
      e.v   = on_grid(pix, 1);
      q1.push_back(e);
      e.v   = on_grid(pix, 2);
      q2.push_back(e);
      f = q1.pop_front(); ev1 = f.v; ed1 = f.l; eo1 = f.val;
      f = q2.pop_front(); ev2 = f.v; ed2 = f.l; eo2 = f.val;
      pix = (pix + 1) % (N*N);
    end else begin
      ev1 = 0; ed1 = 0;
      ev2 = 0; ed2 = 0;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive_cycle(input bit c, input vec_t w);
    ce     = c;
    window = w;
    @(posedge clk);
    model_edge(c);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    ce  = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    total += 3;
    if (out1 !== '0) begin bad++; $display("[TB] FAIL reset.out got=%0h exp=0", out1); end
    if (valid1 !== 1'b0) begin bad++; $display("[TB] FAIL reset.valid got=%0b exp=0", valid1); end
    if (done1 !== 1'b0) begin bad++; $display("[TB] FAIL reset.done got=%0b exp=0", done1); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_cycle(1'b0, rand_vec());
    total += 2;
    if (valid1 !== 1'b0) begin bad++; $display("[TB] FAIL reset.idle_valid got=%0b exp=0", valid1); end
    if (valid2 !== 1'b0) begin bad++; $display("[TB] FAIL reset.idle_valid_s2 got=%0b exp=0", valid2); end
  endtask

  task automatic test_all_ones();
    int nvalid = 0;
    int first = -1;
    int donecyc = -1;
    apply_reset();
    weights = rep(1);
    for (int i = 0; i < 27; i++) begin
      drive_cycle(1'b1, rep(1));
      total++;
      if (valid1 !== ev1) begin bad++; $display("[TB] FAIL ones.valid cyc=%0d got=%0b exp=%0b", i+1, valid1, ev1); end
      total++;
      if (done1 !== ed1) begin bad++; $display("[TB] FAIL ones.done cyc=%0d got=%0b exp=%0b", i+1, done1, ed1); end
      if (ev1) begin
        total++;
        if (int'($signed(out1)) !== 9) begin bad++; $display("[TB] FAIL ones.out cyc=%0d got=%0d exp=9", i+1, $signed(out1)); end
      end
      if (valid1 === 1'b1) begin
        nvalid++;
        if (first < 0) first = i + 1;
      end
      if (done1 === 1'b1 && donecyc < 0) donecyc = i + 1;
    end
    total += 3;
    if (nvalid !== 9) begin bad++; $display("[TB] FAIL ones.count got=%0d exp=9", nvalid); end
    if (first !== 15) begin bad++; $display("[TB] FAIL ones.first_cycle got=%0d exp=15", first); end
    if (donecyc !== 27) begin bad++; $display("[TB] FAIL ones.done_cycle got=%0d exp=27", donecyc); end
  endtask

  task automatic test_extremes();
    int wv [2]   = '{-128, 127};
    int expv [2] = '{147456, -146304};
    int nvalid;
    for (int t = 0; t < 2; t++) begin
      apply_reset();
      weights = rep(wv[t]);
      nvalid = 0;
      for (int i = 0; i < 16; i++) begin
        drive_cycle(1'b1, rep(-128));
        total++;
        if (valid1 !== ev1) begin bad++; $display("[TB] FAIL extreme.valid w=%0d cyc=%0d got=%0b exp=%0b", wv[t], i+1, valid1, ev1); end
        if (valid1 === 1'b1) begin
          nvalid++;
          total++;
          if (int'($signed(out1)) !== expv[t]) begin
            bad++;
            $display("[TB] FAIL extreme.out w=%0d got=%0d exp=%0d", wv[t], $signed(out1), expv[t]);
          end
        end
      end
      total++;
      if (nvalid !== 2) begin bad++; $display("[TB] FAIL extreme.count w=%0d got=%0d exp=2", wv[t], nvalid); end
    end
  endtask

  task automatic test_stride();
    int expv [4] = '{12, 14, 22, 24};
    int got[$];
    vec_t onehot = '0;
    apply_reset();
    onehot[(TAPS/2)*WIDTH +: WIDTH] = WIDTH'(1);
    weights = onehot;
    for (int i = 0; i < 28; i++) begin
      drive_cycle(1'b1, rep(pix));
      total += 2;
      if (valid2 !== ev2) begin bad++; $display("[TB] FAIL stride.valid cyc=%0d got=%0b exp=%0b", i+1, valid2, ev2); end
      if (done2 !== ed2) begin bad++; $display("[TB] FAIL stride.done cyc=%0d got=%0b exp=%0b", i+1, done2, ed2); end
      if (valid2 === 1'b1) got.push_back(int'($signed(out2)));
    end
    total++;
    if (got.size() !== 4) begin
      bad++;
      $display("[TB] FAIL stride.count got=%0d exp=4", got.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        total++;
        if (got[j] !== expv[j]) begin bad++; $display("[TB] FAIL stride.pixel idx=%0d got=%0d exp=%0d", j, got[j], expv[j]); end
      end
    end
  endtask

  task automatic test_stall();
    int explist[$];
    int got[$];
    int ndone = 0;
    bit c;
    vec_t w;
    apply_reset();
    weights = rand_vec();
    for (int i = 0; i < 56; i++) begin
      c = (i % 2 == 0);
      w = rand_vec();
      if (c && on_grid(pix, 1)) explist.push_back(dot(w, weights));
      drive_cycle(c, w);
      total += 2;
      if (valid1 !== ev1) begin bad++; $display("[TB] FAIL stall.valid cyc=%0d got=%0b exp=%0b", i+1, valid1, ev1); end
      if (done1 !== ed1) begin bad++; $display("[TB] FAIL stall.done cyc=%0d got=%0b exp=%0b", i+1, done1, ed1); end
      if (!c) begin
        total++;
        if (valid1 !== 1'b0) begin bad++; $display("[TB] FAIL stall.repeat cyc=%0d got=%0b exp=0", i+1, valid1); end
      end
      if (valid1 === 1'b1) got.push_back(int'($signed(out1)));
      if (done1 === 1'b1) ndone++;
    end
    total += 2;
    if (ndone !== 1) begin bad++; $display("[TB] FAIL stall.done_count got=%0d exp=1", ndone); end
    if (got.size() !== 9) begin
      bad++;
      $display("[TB] FAIL stall.count got=%0d exp=9", got.size());
    end else begin
      for (int j = 0; j < 9; j++) begin
        total++;
        if (got[j] !== explist[j]) begin bad++; $display("[TB] FAIL stall.order idx=%0d got=%0d exp=%0d", j, got[j], explist[j]); end
      end
    end
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), rand_vec());
      total += 2;
      if (valid1 !== ev1) begin bad++; $display("[TB] FAIL random_ce.valid step=%0d got=%0b exp=%0b", i, valid1, ev1); end
      if (done1 !== ed1) begin bad++; $display("[TB] FAIL random_ce.done step=%0d got=%0b exp=%0b", i, done1, ed1); end
      if (ev1) begin
        total++;
        if (int'($signed(out1)) !== eo1) begin bad++; $display("[TB] FAIL random_ce.out step=%0d got=%0d exp=%0d", i, $signed(out1), eo1); end
      end
    end
  endtask

  task automatic test_async_reset();
    int first = -1;
    apply_reset();
    weights = rand_vec();
    for (int i = 0; i < 13; i++) begin
      drive_cycle(1'b1, rand_vec());
      total++;
      if (valid1 !== ev1) begin bad++; $display("[TB] FAIL areset.pre_valid cyc=%0d got=%0b exp=%0b", i+1, valid1, ev1); end
    end
    ce     = 1'b1;
    window = rand_vec();
    #2 rst = 1'b0;
    #1;
    total += 3;
    if (out1 !== '0) begin bad++; $display("[TB] FAIL areset.out got=%0h exp=0", out1); end
    if (valid1 !== 1'b0) begin bad++; $display("[TB] FAIL areset.valid got=%0b exp=0", valid1); end
    if (done1 !== 1'b0) begin bad++; $display("[TB] FAIL areset.done got=%0b exp=0", done1); end
    model_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    drive_cycle(1'b0, rand_vec());
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1, rand_vec());
      total++;
      if (valid1 !== ev1) begin bad++; $display("[TB] FAIL areset.valid step=%0d got=%0b exp=%0b", i+1, valid1, ev1); end
      if (ev1) begin
        total++;
        if (int'($signed(out1)) !== eo1) begin bad++; $display("[TB] FAIL areset.out step=%0d got=%0d exp=%0d", i+1, $signed(out1), eo1); end
      end
      if (valid1 === 1'b1 && first < 0) first = i + 1;
    end
    total++;
    if (first !== 15) begin bad++; $display("[TB] FAIL areset.first got=%0d exp=15", first); end
  endtask

  task automatic test_back_to_back();
    int nvalid = 0;
    int dcyc[$];
    apply_reset();
    weights = rand_vec();
    for (int i = 0; i < 53; i++) begin
      drive_cycle(1'b1, rand_vec());
      total += 3;
      if (valid1 !== ev1) begin bad++; $display("[TB] FAIL b2b.valid cyc=%0d got=%0b exp=%0b", i+1, valid1, ev1); end
      if (done1 !== ed1) begin bad++; $display("[TB] FAIL b2b.done cyc=%0d got=%0b exp=%0b", i+1, done1, ed1); end
      if (valid2 !== ev2) begin bad++; $display("[TB] FAIL b2b.valid_s2 cyc=%0d got=%0b exp=%0b", i+1, valid2, ev2); end
      if (ev1) begin
        total++;
        if (int'($signed(out1)) !== eo1) begin bad++; $display("[TB] FAIL b2b.out cyc=%0d got=%0d exp=%0d", i+1, $signed(out1), eo1); end
      end
      if (valid1 === 1'b1) nvalid++;
      if (done1 === 1'b1) dcyc.push_back(i + 1);
    end
    total += 2;
    if (nvalid !== 18) begin bad++; $display("[TB] FAIL b2b.count got=%0d exp=18", nvalid); end
    if (dcyc.size() !== 2) begin
      bad++;
      $display("[TB] FAIL b2b.done_count got=%0d exp=2", dcyc.size());
    end else begin
      total += 2;
      if (dcyc[0] !== 27) begin bad++; $display("[TB] FAIL b2b.done1_cycle got=%0d exp=27", dcyc[0]); end
      if (dcyc[1] !== 52) begin bad++; $display("[TB] FAIL b2b.done2_cycle got=%0d exp=52", dcyc[1]); end
    end
  endtask

  initial begin
    rst     = 1'b1;
    ce      = 1'b0;
    window  = '0;
    weights = '0;
    test_reset();
    test_all_ones();
    test_extremes();
    test_stride();
    test_stall();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
